// File: rtl/jtag_dtm_sync.sv
// RISC-V JTAG DTM with the JTAG pins oversampled in the SoC clock domain.
// TAP controller, IDCODE/DTMCS/DMI/BYPASS registers and the DMI request/response FSM.
module jtag_dtm_sync #(
   parameter logic [31:0] IDCODE      = 32'h1000_0DB3,
   parameter int unsigned ABITS       = 7,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             tck_i,
   input  logic             tms_i,
   input  logic             tdi_i,
   output logic             tdo_o,
   output logic             tdo_oe_o,
   output logic             dmi_req_valid_o,
   input  logic             dmi_req_ready_i,
   output logic [ABITS-1:0] dmi_req_addr_o,
   output logic [1:0]       dmi_req_op_o,
   output logic [31:0]      dmi_req_data_o,
   input  logic             dmi_resp_valid_i,
   output logic             dmi_resp_ready_o,
   input  logic [31:0]      dmi_resp_data_i,
   input  logic [1:0]       dmi_resp_resp_i,
   output logic             dmi_hardreset_o
);

   localparam int unsigned SrW  = ABITS + 34;
   localparam int unsigned IdxW = $clog2(SrW);

   typedef enum logic [3:0] {
      StTlr, StRti, StSelDr, StCapDr, StShDr, StEx1Dr, StPauDr, StEx2Dr, StUpdDr,
      StSelIr, StCapIr, StShIr, StEx1Ir, StPauIr, StEx2Ir, StUpdIr
   } tap_e;

   typedef enum logic [1:0] {DmiIdle, DmiReq, DmiWait} dmi_e;

   logic [SYNC_STAGES-1:0] tck_sq_q, tck_sq_d, tms_sq_q, tms_sq_d, tdi_sq_q, tdi_sq_d;
   logic                   tck_prev_q, tck_s, tms_s, tdi_s, tck_rise, tck_fall;
   tap_e                   tap_q, tap_d, tap_nxt;
   dmi_e                   dmi_q, dmi_d;
   logic [4:0]             ir_q, ir_d;
   logic [SrW-1:0]         sr_q, sr_d;
   logic [IdxW-1:0]        msb;
   logic                   tdo_q, tdo_d, hardreset_q, hardreset_d;
   logic [ABITS-1:0]       req_addr_q, req_addr_d, last_addr_q, last_addr_d;
   logic [31:0]            req_data_q, req_data_d, last_rdata_q, last_rdata_d;
   logic [1:0]             req_op_q, req_op_d, dmistat_q, dmistat_d, cap_op;
   logic [31:0]            dtmcs_cap;
   logic                   sel_idcode, sel_dtmcs, sel_dmi, upd_dr, busy_err, resp_err;

   assign tck_sq_d = SYNC_STAGES'({tck_sq_q, tck_i});
   assign tms_sq_d = SYNC_STAGES'({tms_sq_q, tms_i});
   assign tdi_sq_d = SYNC_STAGES'({tdi_sq_q, tdi_i});
   assign tck_s    = tck_sq_q[SYNC_STAGES-1];
   assign tms_s    = tms_sq_q[SYNC_STAGES-1];
   assign tdi_s    = tdi_sq_q[SYNC_STAGES-1];
   assign tck_rise = tck_s & ~tck_prev_q;
   assign tck_fall = ~tck_s & tck_prev_q;

   assign sel_idcode = (ir_q == 5'h01);
   assign sel_dtmcs  = (ir_q == 5'h10);
   assign sel_dmi    = (ir_q == 5'h11);
   assign upd_dr     = tck_rise && (tap_q == StUpdDr);
   assign cap_op     = (dmi_q != DmiIdle) ? 2'd3 : dmistat_q;
   assign dtmcs_cap  = {14'b0, 2'b00, 1'b0, 3'd1, dmistat_q, 6'(ABITS), 4'd1};

   always_comb begin
      tap_nxt = tap_q;
      unique case (tap_q)
         StTlr:   tap_nxt = tms_s ? StTlr   : StRti;
         StRti:   tap_nxt = tms_s ? StSelDr : StRti;
         StSelDr: tap_nxt = tms_s ? StSelIr : StCapDr;
         StCapDr: tap_nxt = tms_s ? StEx1Dr : StShDr;
         StShDr:  tap_nxt = tms_s ? StEx1Dr : StShDr;
         StEx1Dr: tap_nxt = tms_s ? StUpdDr : StPauDr;
         StPauDr: tap_nxt = tms_s ? StEx2Dr : StPauDr;
         StEx2Dr: tap_nxt = tms_s ? StUpdDr : StShDr;
         StUpdDr: tap_nxt = tms_s ? StSelDr : StRti;
         StSelIr: tap_nxt = tms_s ? StTlr   : StCapIr;
         StCapIr: tap_nxt = tms_s ? StEx1Ir : StShIr;
         StShIr:  tap_nxt = tms_s ? StEx1Ir : StShIr;
         StEx1Ir: tap_nxt = tms_s ? StUpdIr : StPauIr;
         StPauIr: tap_nxt = tms_s ? StEx2Ir : StPauIr;
         StEx2Ir: tap_nxt = tms_s ? StUpdIr : StShIr;
         StUpdIr: tap_nxt = tms_s ? StSelDr : StRti;
      endcase
   end

   // TAP state, IR and the shared shift register; TDI enters at the active length's MSB.
   always_comb begin
      tap_d = tck_rise ? tap_nxt : tap_q;
      ir_d  = ir_q;
      sr_d  = sr_q;
      tdo_d = tck_fall ? sr_q[0] : tdo_q;
      msb   = '0;
      if (tap_q == StShIr)               msb = IdxW'(4);
      else if (sel_dmi)                  msb = IdxW'(SrW - 1);
      else if (sel_idcode || sel_dtmcs)  msb = IdxW'(31);
      if (tck_rise) begin
         case (tap_q)
            StCapIr: sr_d = SrW'(5'b00001);
            StCapDr: begin
               if (sel_dmi)         sr_d = {last_addr_q, last_rdata_q, cap_op};
               else if (sel_idcode) sr_d = SrW'(IDCODE);
               else if (sel_dtmcs)  sr_d = SrW'(dtmcs_cap);
               else                 sr_d = '0;
            end
            StShIr, StShDr: begin
               sr_d      = sr_q >> 1;
               sr_d[msb] = tdi_s;
            end
            StUpdIr: ir_d = sr_q[4:0];
            default: ;
         endcase
         if (tap_nxt == StTlr) ir_d = 5'h01;
      end
   end

   always_comb begin
      dmi_d        = dmi_q;
      req_addr_d   = req_addr_q;
      req_data_d   = req_data_q;
      req_op_d     = req_op_q;
      last_addr_d  = last_addr_q;
      last_rdata_d = last_rdata_q;
      dmistat_d    = dmistat_q;
      hardreset_d  = 1'b0;
      busy_err     = 1'b0;
      resp_err     = 1'b0;
      case (dmi_q)
         DmiReq:  if (dmi_req_ready_i) dmi_d = DmiWait;
         DmiWait: if (dmi_resp_valid_i) begin
            dmi_d = DmiIdle;
            if (req_op_q == 2'd1) last_rdata_d = dmi_resp_data_i;
            resp_err = (dmi_resp_resp_i != 2'd0);
         end
         default: ;
      endcase
      if (upd_dr && sel_dmi && dmistat_q == 2'd0) begin
         if (dmi_q != DmiIdle) begin
            busy_err = 1'b1;
         end else if (sr_q[1:0] == 2'd1 || sr_q[1:0] == 2'd2) begin
            req_op_d    = sr_q[1:0];
            req_data_d  = sr_q[33:2];
            req_addr_d  = sr_q[SrW-1:34];
            last_addr_d = sr_q[SrW-1:34];
            dmi_d       = DmiReq;
         end
      end
      if (upd_dr && sel_dtmcs) begin
         if (sr_q[16] || sr_q[17]) dmistat_d = 2'd0;
         // Hard reset overrides any handshake landing in the same cycle.
         if (sr_q[17]) begin
            dmi_d       = DmiIdle;
            hardreset_d = 1'b1;
         end
      end
      if (resp_err && dmistat_d < 2'd2) dmistat_d = 2'd2;
      if (busy_err)                     dmistat_d = 2'd3;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         tck_sq_q     <= '0;
         tms_sq_q     <= '0;
         tdi_sq_q     <= '0;
         tck_prev_q   <= 1'b0;
         tap_q        <= StTlr;
         ir_q         <= 5'h01;
         sr_q         <= '0;
         tdo_q        <= 1'b0;
         dmi_q        <= DmiIdle;
         req_addr_q   <= '0;
         req_data_q   <= '0;
         req_op_q     <= '0;
         last_addr_q  <= '0;
         last_rdata_q <= '0;
         dmistat_q    <= '0;
         hardreset_q  <= 1'b0;
      end else begin
         tck_sq_q     <= tck_sq_d;
         tms_sq_q     <= tms_sq_d;
         tdi_sq_q     <= tdi_sq_d;
         tck_prev_q   <= tck_s;
         tap_q        <= tap_d;
         ir_q         <= ir_d;
         sr_q         <= sr_d;
         tdo_q        <= tdo_d;
         dmi_q        <= dmi_d;
         req_addr_q   <= req_addr_d;
         req_data_q   <= req_data_d;
         req_op_q     <= req_op_d;
         last_addr_q  <= last_addr_d;
         last_rdata_q <= last_rdata_d;
         dmistat_q    <= dmistat_d;
         hardreset_q  <= hardreset_d;
      end
   end

   assign tdo_o            = tdo_q;
   assign tdo_oe_o         = (tap_q == StShDr) || (tap_q == StShIr);
   assign dmi_req_valid_o  = (dmi_q == DmiReq);
   assign dmi_resp_ready_o = (dmi_q == DmiWait);
   assign dmi_req_addr_o   = req_addr_q;
   assign dmi_req_data_o   = req_data_q;
   assign dmi_req_op_o     = req_op_q;
   assign dmi_hardreset_o  = hardreset_q;

endmodule

// File: tb/tb_jtag_dtm_sync.sv
// Bench for jtag_dtm_sync: bit-banged JTAG scans checked against a register-level
// model of the DTM, with a hand-driven DMI responder.
module tb_jtag_dtm_sync;

   localparam int unsigned ABITS = 7;
   localparam logic [31:0] IDC   = 32'h1000_0DB3;
   localparam int          HALF  = 5;

   logic clk = 1'b0;
   logic rst_n;
   logic tck_i, tms_i, tdi_i, tdo_o, tdo_oe_o;
   logic dmi_req_valid_o, dmi_req_ready_i, dmi_resp_valid_i, dmi_resp_ready_o;
   logic [ABITS-1:0] dmi_req_addr_o;
   logic [1:0]  dmi_req_op_o, dmi_resp_resp_i;
   logic [31:0] dmi_req_data_o, dmi_resp_data_i;
   logic dmi_hardreset_o;

   always #5 clk = ~clk;

   jtag_dtm_sync #(.IDCODE(IDC), .ABITS(ABITS), .SYNC_STAGES(2)) dut (
      .clk_i(clk), .rst_ni(rst_n), .tck_i(tck_i), .tms_i(tms_i), .tdi_i(tdi_i),
      .tdo_o(tdo_o), .tdo_oe_o(tdo_oe_o),
      .dmi_req_valid_o(dmi_req_valid_o), .dmi_req_ready_i(dmi_req_ready_i),
      .dmi_req_addr_o(dmi_req_addr_o), .dmi_req_op_o(dmi_req_op_o),
      .dmi_req_data_o(dmi_req_data_o), .dmi_resp_valid_i(dmi_resp_valid_i),
      .dmi_resp_ready_o(dmi_resp_ready_o), .dmi_resp_data_i(dmi_resp_data_i),
      .dmi_resp_resp_i(dmi_resp_resp_i), .dmi_hardreset_o(dmi_hardreset_o)
   );

   int n_chk = 0, n_bad = 0, oe_err = 0, hr_cnt = 0, m_hr = 0;

   // Reference model: architectural DTM state only.
   logic [4:0]       m_ir;
   logic [1:0]       m_dmistat;
   bit               m_busy;
   logic [ABITS-1:0] m_last_addr, m_req_addr;
   logic [31:0]      m_last_rdata, m_req_data;
   logic [1:0]       m_req_op;

   always @(negedge clk) if (dmi_hardreset_o === 1'b1) hr_cnt++;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_ir = 5'h01; m_dmistat = 2'd0; m_busy = 1'b0;
      m_last_addr = '0; m_last_rdata = '0;
   endtask

   function automatic int reg_len(input logic [4:0] ir);
      if (ir == 5'h01 || ir == 5'h10) return 32;
      if (ir == 5'h11) return ABITS + 34;
      return 1;
   endfunction

   function automatic logic [63:0] cap_val();
      logic [1:0] op;
      if (m_ir == 5'h01) return 64'(IDC);
      if (m_ir == 5'h10)
         return 64'(32'h1000 + 32'(m_dmistat) * 1024 + 32'(ABITS) * 16 + 32'd1);
      if (m_ir == 5'h11) begin
         op = m_busy ? 2'd3 : m_dmistat;
         return 64'({m_last_addr, m_last_rdata, op});
      end
      return 64'd0;
   endfunction

   task automatic tck_cycle(input logic tms, input logic tdi, input logic exp_oe,
                            output logic tdo);
      tms_i = tms;
      tdi_i = tdi;
      repeat (HALF) @(negedge clk);
      tdo = tdo_o;
      if (tdo_oe_o !== exp_oe) oe_err++;
      tck_i = 1'b1;
      repeat (HALF) @(negedge clk);
      tck_i = 1'b0;
   endtask

   // Starts and ends in Run-Test/Idle.
   task automatic scan(input bit is_ir, input logic [63:0] din, input int len,
                       output logic [63:0] dout);
      logic t;
      dout   = '0;
      oe_err = 0;
      tck_cycle(1'b1, 1'b0, 1'b0, t);
      if (is_ir) tck_cycle(1'b1, 1'b0, 1'b0, t);
      tck_cycle(1'b0, 1'b0, 1'b0, t);
      tck_cycle(1'b0, 1'b0, 1'b0, t);
      for (int i = 0; i < len; i++) begin
         tck_cycle(i == len - 1, din[i], 1'b1, t);
         dout[i] = t;
      end
      tck_cycle(1'b1, 1'b0, 1'b0, t);
      tck_cycle(1'b0, 1'b0, 1'b0, t);
      check_eq("tdo_oe", 64'(oe_err), 64'd0);
   endtask

   task automatic ir_set(input logic [4:0] ir);
      logic [63:0] dout;
      scan(1'b1, 64'(ir), 5, dout);
      check_eq("ir_capture", 64'(dout[4:0]), 64'(5'b00001));
      m_ir = ir;
   endtask

   task automatic dmi_model(input logic [63:0] din);
      logic [1:0] op;
      op = din[1:0];
      if (m_dmistat != 2'd0) return;
      if (m_busy) m_dmistat = 2'd3;
      else if (op == 2'd1 || op == 2'd2) begin
         m_busy      = 1'b1;
         m_req_op    = op;
         m_req_data  = din[33:2];
         m_req_addr  = din[ABITS+33:34];
         m_last_addr = din[ABITS+33:34];
      end
   endtask

   task automatic dr(input string tag, input logic [63:0] din, input int len);
      logic [63:0] cap, exp, dout;
      int r;
      r   = reg_len(m_ir);
      cap = cap_val();
      exp = '0;
      for (int i = 0; i < len; i++) exp[i] = (i < r) ? cap[i] : din[i - r];
      scan(1'b0, din, len, dout);
      check_eq(tag, dout, exp);
      if (m_ir == 5'h10) begin
         if (din[17]) begin
            m_hr++; m_busy = 1'b0; m_dmistat = 2'd0;
         end else if (din[16]) m_dmistat = 2'd0;
      end else if (m_ir == 5'h11) dmi_model(din);
   endtask

   function automatic logic [63:0] dmi_word(input logic [ABITS-1:0] a, input logic [31:0] d,
                                            input logic [1:0] op);
      return 64'({a, d, op});
   endfunction

   task automatic serve_req(input int delay);
      int drops = 0;
      check_eq("req_valid", 64'(dmi_req_valid_o), 64'd1);
      check_eq("req_fields", 64'({dmi_req_addr_o, dmi_req_data_o, dmi_req_op_o}),
               64'({m_req_addr, m_req_data, m_req_op}));
      repeat (delay) begin
         @(negedge clk);
         if (dmi_req_valid_o !== 1'b1) drops++;
      end
      check_eq("req_hold", 64'(drops), 64'd0);
      dmi_req_ready_i = 1'b1;
      @(negedge clk);
      dmi_req_ready_i = 1'b0;
      check_eq("req_accepted", 64'({dmi_req_valid_o, dmi_resp_ready_o}), 64'(2'b01));
   endtask

   task automatic serve_resp(input logic [31:0] rdata, input logic [1:0] resp);
      check_eq("resp_ready", 64'(dmi_resp_ready_o), 64'd1);
      dmi_resp_valid_i = 1'b1;
      dmi_resp_data_i  = rdata;
      dmi_resp_resp_i  = resp;
      @(negedge clk);
      dmi_resp_valid_i = 1'b0;
      check_eq("resp_done", 64'(dmi_resp_ready_o), 64'd0);
      m_busy = 1'b0;
      if (m_req_op == 2'd1) m_last_rdata = rdata;
      if (resp != 2'd0 && m_dmistat < 2'd2) m_dmistat = 2'd2;
   endtask

   initial begin
      logic t;
      logic [4:0] rir;
      int k;
      tck_i = 0; tms_i = 0; tdi_i = 0; rst_n = 0;
      dmi_req_ready_i = 0; dmi_resp_valid_i = 0; dmi_resp_data_i = '0; dmi_resp_resp_i = '0;
      model_reset();
      repeat (3) @(negedge clk);
      check_eq("rst_tdo", 64'({tdo_o, tdo_oe_o}), 64'd0);
      check_eq("rst_hs", 64'({dmi_req_valid_o, dmi_resp_ready_o, dmi_hardreset_o}), 64'd0);
      check_eq("rst_fields", 64'({dmi_req_addr_o, dmi_req_data_o, dmi_req_op_o}), 64'd0);
      rst_n = 1;
      repeat (5) tck_cycle(1'b1, 1'b0, 1'b0, t);
      tck_cycle(1'b0, 1'b0, 1'b0, t);

      dr("idcode", 64'($urandom), 32);
      ir_set(5'h10);
      dr("dtmcs", 64'd0, 32);

      ir_set(5'h11);
      dr("dmi_wr", dmi_word(7'h10, 32'h1, 2'd2), ABITS + 34);
      serve_req(3);
      serve_resp($urandom, 2'd0);
      dr("dmi_rd", dmi_word(7'h11, 32'h0, 2'd1), ABITS + 34);
      serve_req(0);
      serve_resp(32'hDEAD_BEEF, 2'd0);
      dr("dmi_rdata", dmi_word(7'h0, 32'h0, 2'd0), ABITS + 34);

      dr("dmi_stall", dmi_word(7'h05, 32'h1234_5678, 2'd2), ABITS + 34);
      serve_req(1);
      dr("dmi_busy", dmi_word(7'h06, 32'h9, 2'd2), ABITS + 34);
      check_eq("no_new_req", 64'(dmi_req_valid_o), 64'd0);
      dr("dmi_op3", dmi_word(7'h0, 32'h0, 2'd0), ABITS + 34);
      ir_set(5'h10);
      dr("dtmcs_busy", 64'd0, 32);
      dr("dtmcs_clr", 64'(32'h1_0000), 32);
      dr("dtmcs_clred", 64'd0, 32);
      serve_resp(32'h0, 2'd2);
      dr("dtmcs_err", 64'd0, 32);
      dr("dtmcs_clr2", 64'(32'h1_0000), 32);

      ir_set(5'h11);
      dr("dmi_rd2", dmi_word(7'h03, 32'h0, 2'd1), ABITS + 34);
      serve_req(0);
      ir_set(5'h10);
      dr("dtmcs_hard", 64'(32'h2_0000), 32);
      check_eq("hardreset_cnt", 64'(hr_cnt), 64'(m_hr));
      check_eq("hard_idle", 64'({dmi_req_valid_o, dmi_resp_ready_o}), 64'd0);
      ir_set(5'h11);
      dr("dmi_after_hard", dmi_word(7'h0, 32'h0, 2'd0), ABITS + 34);

      ir_set(5'h1F);
      dr("bypass_1f", 64'(4'b1101), 4);
      ir_set(5'h05);
      dr("bypass_05", 64'(4'b1101), 4);

      for (int it = 0; it < 30; it++) begin
         k = $urandom_range(0, 3);
         case (k)
            0: begin
               if (m_ir != 5'h11) ir_set(5'h11);
               dr("rnd_dmi", dmi_word(7'($urandom), $urandom, 2'($urandom_range(1, 2))),
                  ABITS + 34);
               if (m_busy) begin
                  serve_req($urandom_range(0, 4));
                  serve_resp($urandom, ($urandom_range(0, 3) == 0) ? 2'd2 : 2'd0);
               end else check_eq("rnd_no_req", 64'(dmi_req_valid_o), 64'd0);
            end
            1: begin
               if (m_ir != 5'h11) ir_set(5'h11);
               dr("rnd_dmi_nop", dmi_word(7'($urandom), $urandom,
                  ($urandom_range(0, 1) == 0) ? 2'd0 : 2'd3), ABITS + 34);
            end
            2: begin
               if (m_ir != 5'h10) ir_set(5'h10);
               dr("rnd_dtmcs", 64'(($urandom & 32'hFFFD_FFFF) |
                  (($urandom_range(0, 3) == 0) ? 32'h2_0000 : 32'h0)), 32);
            end
            default: begin
               rir = 5'($urandom);
               if (rir == 5'h10 || rir == 5'h11) rir = 5'h1F;
               ir_set(rir);
               dr("rnd_bypass_idcode", {$urandom, $urandom},
                  (rir == 5'h01) ? 32 : $urandom_range(2, 10));
            end
         endcase
      end
      check_eq("rnd_hardreset_cnt", 64'(hr_cnt), 64'(m_hr));

      if (m_ir != 5'h11) ir_set(5'h11);
      if (m_dmistat != 2'd0) begin
         ir_set(5'h10);
         dr("pre_rst_clr", 64'(32'h1_0000), 32);
         ir_set(5'h11);
      end
      dr("pre_rst_wr", dmi_word(7'h22, 32'hCAFE_F00D, 2'd2), ABITS + 34);
      check_eq("pre_rst_valid", 64'(dmi_req_valid_o), 64'd1);
      @(negedge clk);
      rst_n = 0;
      #1;
      check_eq("async_rst", 64'({dmi_req_valid_o, dmi_resp_ready_o, tdo_oe_o, tdo_o}), 64'd0);
      repeat (2) @(negedge clk);
      rst_n = 1;
      model_reset();
      tck_cycle(1'b0, 1'b0, 1'b0, t);
      dr("post_rst_idcode", 64'($urandom), 32);
      ir_set(5'h11);
      dr("post_rst_dmi", dmi_word(7'h0, 32'h0, 2'd0), ABITS + 34);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
